muldiv_ex: RTL and testbench

- Execute-stage multi-cycle multiply/divide unit for the 64-bit RV64M datapath.
- It generates the EX-side wait request (e_wait) consumed by the pipeline hazard unit. It holds e_wait high while a division is in flight, then presents the result for one retirement.
- Multiplies complete combinationally. Divides/remainders use a radix-2 restoring iterator, one quotient bit per cycle.

---
 rtl/muldiv_ex_if.sv | 27 ++
 rtl/muldiv_ex.sv | 148 ++++++++++++++
 tb/tb_muldiv_ex.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_ex_if.sv
// Execute-stage M-extension handshake bundle between the pipeline and muldiv_ex.
// Pipeline side (master) drives the instruction, operands, stall and flush.
// Unit side (slave) returns the wait request, the result and a busy indication.
interface muldiv_ex_if #(
   parameter int XLEN = 64
);
   logic            valid;   // live M-extension instruction in EX
   logic [2:0]      op;      // 0=MUL 1=MULH 2=MULHU 3=MULHSU 4=DIV 5=DIVU 6=REM 7=REMU
   logic            word;    // RV64 W-variant
   logic [XLEN-1:0] a;       // rs1 operand
   logic [XLEN-1:0] b;       // rs2 operand
   logic            stall;   // EX held for reasons outside this unit
   logic            flush;   // EX instruction is being killed
   logic            e_wait;  // stall F/D/E, bubble M
   logic [XLEN-1:0] result;  // valid when valid=1 and e_wait=0
   logic            busy;    // divider FSM not idle

   modport master (
      output valid, op, word, a, b, stall, flush,
      input  e_wait, result, busy
   );

   modport slave (
      input  valid, op, word, a, b, stall, flush,
      output e_wait, result, busy
   );
endinterface

// File: rtl/muldiv_ex.sv
// RV64M execute unit: combinational multiply, radix-2 restoring divide (1 bit/cycle).
// Ports: clk, reset (async active-high), bus (muldiv_ex_if.slave: valid/op/word/a/b/stall/flush in,
// e_wait/result/busy out). Divide holds e_wait 65 cycles (33 for W, 1 for div-by-zero/overflow).
module muldiv_ex #(
   parameter int XLEN = 64
) (
   input  logic        clk,
   input  logic        reset,
   muldiv_ex_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state, state_nx;
   logic [6:0]      count;
   logic [XLEN-1:0] quo, rem, dvs;
   logic            q_neg, r_neg;
   logic [2:0]      op_q;
   logic            word_q;

   // ---------------- multiply (combinational, any state) ----------------
   logic         a_sx, b_sx;
   logic [127:0] ma, mb, prod;
   logic [31:0]  mulw;
   logic [63:0]  mul_res;

   always_comb begin
      a_sx    = (bus.op == 3'd1) || (bus.op == 3'd3);
      b_sx    = (bus.op == 3'd1);
      ma      = {{64{a_sx & bus.a[63]}}, bus.a};
      mb      = {{64{b_sx & bus.b[63]}}, bus.b};
      // Low 128 bits of the extended-operand product equal the true product.
      prod    = ma * mb;
      mulw    = bus.a[31:0] * bus.b[31:0];
      mul_res = prod[127:64];
      if (bus.op == 3'd0)
         mul_res = bus.word ? {{32{mulw[31]}}, mulw} : prod[63:0];
   end

   // ---------------- divide operand preparation ----------------
   logic        d_signed, sa, sb, div0, ovf, start;
   logic [63:0] a_ext, b_ext, abs_a, abs_b, min_neg;

   always_comb begin
      d_signed = ~bus.op[0];
      a_ext    = bus.a;
      b_ext    = bus.b;
      if (bus.word) begin
         a_ext = {{32{d_signed & bus.a[31]}}, bus.a[31:0]};
         b_ext = {{32{d_signed & bus.b[31]}}, bus.b[31:0]};
      end
      sa      = d_signed & a_ext[63];
      sb      = d_signed & b_ext[63];
      abs_a   = sa ? -a_ext : a_ext;
      abs_b   = sb ? -b_ext : b_ext;
      min_neg = bus.word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
      div0    = (b_ext == 64'd0);
      ovf     = d_signed && (a_ext == min_neg) && (b_ext == {64{1'b1}});
      start   = (state == IDLE) && bus.valid && bus.op[2] && !bus.flush;
   end

   // ---------------- restoring iteration step ----------------
   logic [64:0] shifted;
   logic [63:0] diff;
   logic        ge;

   always_comb begin
      shifted = {rem, quo[63]};
      ge      = (shifted >= {1'b0, dvs});
      // When ge holds the true difference is below 2^64, so 64-bit wrap is exact.
      diff    = shifted[63:0] - dvs;
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      bus.e_wait = 1'b0;
      case (state)
         IDLE: begin
            bus.e_wait = start;
            if (start) state_nx = (div0 || ovf) ? DONE : BUSY;
         end
         BUSY: begin
            bus.e_wait = !bus.flush;
            if (bus.flush)        state_nx = IDLE;
            else if (count == 7'd1) state_nx = DONE;
         end
         DONE: begin
            if (bus.flush || !bus.stall) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count  <= '0;
         quo    <= '0;
         rem    <= '0;
         dvs    <= '0;
         q_neg  <= 1'b0;
         r_neg  <= 1'b0;
         op_q   <= '0;
         word_q <= 1'b0;
      end else if (start) begin
         op_q   <= bus.op;
         word_q <= bus.word;
         count  <= bus.word ? 7'd32 : 7'd64;
         dvs    <= abs_b;
         if (div0 || ovf) begin
            // Final values stored directly; no sign fix-up needed in DONE.
            quo   <= div0 ? {64{1'b1}} : a_ext;
            rem   <= div0 ? a_ext : 64'd0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
         end else begin
            // W dividend is left-justified so its top bit shifts out first.
            quo   <= bus.word ? {abs_a[31:0], 32'd0} : abs_a;
            rem   <= '0;
            q_neg <= sa ^ sb;
            r_neg <= sa;
         end
      end else if (state == BUSY) begin
         rem   <= ge ? diff : shifted[63:0];
         quo   <= {quo[62:0], ge};
         count <= count - 7'd1;
      end
   end

   // ---------------- result ----------------
   logic [63:0] sel, fixed, div_res;

   always_comb begin
      sel     = op_q[1] ? rem : quo;
      fixed   = (!op_q[0] && (op_q[1] ? r_neg : q_neg)) ? -sel : sel;
      div_res = word_q ? {{32{fixed[31]}}, fixed[31:0]} : fixed;
      if (!bus.valid)          bus.result = '0;
      else if (!bus.op[2])     bus.result = mul_res;
      else if (state == DONE)  bus.result = div_res;
      else                     bus.result = '0;
      bus.busy = (state != IDLE);
   end
endmodule

// File: tb/tb_muldiv_ex.sv
// Self-checking bench for muldiv_ex: directed vector table, random ops vs. arithmetic model,
// and hand sequences for stall-at-DONE, flush mid-divide and reset mid-divide.
module tb_muldiv_ex;
   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   muldiv_ex_if #(.XLEN(64)) bus();
   muldiv_ex #(.XLEN(64)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Reference: RISC-V M semantics computed with plain arithmetic.
   function automatic logic [63:0] model(input logic [2:0] op, input logic w,
                                         input logic [63:0] x, input logic [63:0] y);
      logic signed [127:0] sx, sy, sp;
      logic [127:0]        ux, uy, up;
      logic [31:0]         t32;
      logic signed [31:0]  x32, y32;
      longint              lx, ly;
      logic [63:0]         r;
      sx = $signed(x); sy = $signed(y); ux = x; uy = y;
      lx = x; ly = y; x32 = x[31:0]; y32 = y[31:0];
      r = '0;
      case (op)
         3'd0: begin
            if (w) begin t32 = x[31:0] * y[31:0]; r = {{32{t32[31]}}, t32}; end
            else r = x * y;
         end
         3'd1: begin sp = sx * sy; r = sp[127:64]; end
         3'd2: begin up = ux * uy; r = up[127:64]; end
         3'd3: begin sp = sx * $signed(uy); r = sp[127:64]; end
         3'd4, 3'd6: begin
            if (w) begin
               if (y32 == 0)                              t32 = (op == 3'd4) ? 32'hFFFF_FFFF : x32;
               else if (x32 == 32'sh8000_0000 && y32 == -1) t32 = (op == 3'd4) ? x32 : 32'd0;
               else                                       t32 = (op == 3'd4) ? x32 / y32 : x32 % y32;
               r = {{32{t32[31]}}, t32};
            end else begin
               if (ly == 0)                                 r = (op == 3'd4) ? '1 : x;
               else if (x == 64'h8000_0000_0000_0000 && ly == -1) r = (op == 3'd4) ? x : 64'd0;
               else                                         r = (op == 3'd4) ? lx / ly : lx % ly;
            end
         end
         default: begin
            if (w) begin
               if (y[31:0] == 0) t32 = (op == 3'd5) ? 32'hFFFF_FFFF : x[31:0];
               else              t32 = (op == 3'd5) ? x[31:0] / y[31:0] : x[31:0] % y[31:0];
               r = {{32{t32[31]}}, t32};
            end else begin
               if (y == 0) r = (op == 3'd5) ? '1 : x;
               else        r = (op == 3'd5) ? x / y : x % y;
            end
         end
      endcase
      return r;
   endfunction

   // Expected number of cycles with e_wait high (issue cycle included).
   function automatic int model_waits(input logic [2:0] op, input logic w,
                                      input logic [63:0] x, input logic [63:0] y);
      logic sgn, zero, ov;
      if (!op[2]) return 0;
      sgn  = !op[0];
      zero = w ? (y[31:0] == 0) : (y == 0);
      ov   = sgn && (w ? (x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF)
                       : (x == 64'h8000_0000_0000_0000 && y == '1));
      if (zero || ov) return 1;
      return w ? 33 : 65;
   endfunction

   // Issue one op at a negedge; scramble operands while waiting; sample result on retirement.
   task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] x,
                        input logic [63:0] y, output logic [63:0] res, output int waits);
      @(negedge clk);
      bus.valid = 1'b1; bus.op = op; bus.word = w; bus.a = x; bus.b = y;
      waits = 0;
      #1;
      while (bus.e_wait && waits < 200) begin
         waits++;
         @(negedge clk);
         bus.a = {$urandom, $urandom};
         bus.b = {$urandom, $urandom};
         #1;
      end
      res = bus.result;
      @(posedge clk); #1;
      bus.valid = 1'b0;
   endtask

   typedef struct {
      logic [2:0]  op;
      logic        w;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
      int          waits;
   } vec_t;

   vec_t        vecs[16];
   logic [63:0] res, ra, rb, expv;
   int          waits, n;
   logic [2:0]  rop;
   logic        rw;

   initial begin
      vecs[0]  = '{3'd4, 1'b0, 64'd100, 64'd7, 64'd14, 65};
      vecs[1]  = '{3'd6, 1'b0, 64'd100, 64'd7, 64'd2, 65};
      vecs[2]  = '{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65};
      vecs[3]  = '{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65};
      vecs[4]  = '{3'd5, 1'b0, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
      vecs[5]  = '{3'd7, 1'b0, 64'd123, 64'd0, 64'd123, 1};
      vecs[6]  = '{3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
      vecs[7]  = '{3'd6, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1};
      vecs[8]  = '{3'd5, 1'b1, 64'hFFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 33};
      vecs[9]  = '{3'd1, 1'b0, '1, '1, 64'd0, 0};
      vecs[10] = '{3'd2, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 0};
      vecs[11] = '{3'd0, 1'b1, 64'h1_0000, 64'h1_0000, 64'd0, 0};
      vecs[12] = '{3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1};
      vecs[13] = '{3'd0, 1'b0, 64'd3, 64'd5, 64'd15, 0};
      vecs[14] = '{3'd6, 1'b1, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33};
      vecs[15] = '{3'd4, 1'b1, 64'hDEAD_BEEF_0000_0064, 64'd7, 64'd14, 33};

      bus.valid = 0; bus.op = 0; bus.word = 0; bus.a = 0; bus.b = 0;
      bus.stall = 0; bus.flush = 0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("reset e_wait", {63'd0, bus.e_wait}, 64'd0);
      check("reset result", bus.result, 64'd0);
      check("reset busy", {63'd0, bus.busy}, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // Directed table
      for (int i = 0; i < 16; i++) begin
         issue(vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b, res, waits);
         check($sformatf("vec%0d result", i), res, vecs[i].exp);
         check($sformatf("vec%0d waits", i), 64'(waits), 64'(vecs[i].waits));
      end

      // Random ops against the model
      for (int i = 0; i < 40; i++) begin
         rop = 3'($urandom_range(0, 7));
         rw  = ($urandom_range(0, 2) == 0);
         if (rop inside {3'd1, 3'd2, 3'd3}) rw = 1'b0;
         ra  = {$urandom, $urandom};
         rb  = {$urandom, $urandom};
         case ($urandom_range(0, 7))
            0: rb = 64'd0;
            1: begin rb = '1; ra = rw ? 64'h8000_0000 : 64'h8000_0000_0000_0000; end
            2: rb = 64'($urandom_range(1, 20));
            3: rb = {32'd0, $urandom};
            default: ;
         endcase
         expv = model(rop, rw, ra, rb);
         issue(rop, rw, ra, rb, res, waits);
         check($sformatf("rand%0d op%0d w%0d result", i, rop, rw), res, expv);
         check($sformatf("rand%0d waits", i), 64'(waits), 64'(model_waits(rop, rw, ra, rb)));
      end

      // Stall held at DONE for 3 cycles
      @(negedge clk);
      bus.valid = 1; bus.op = 3'd4; bus.word = 0; bus.a = 64'd1000; bus.b = 64'd10;
      n = 0;
      #1;
      while (bus.e_wait && n < 200) begin n++; @(negedge clk); #1; end
      check("stall wait count", 64'(n), 64'd65);
      bus.stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         check($sformatf("stall%0d result", k), bus.result, 64'd100);
         check($sformatf("stall%0d busy", k), {63'd0, bus.busy}, 64'd1);
         check($sformatf("stall%0d e_wait", k), {63'd0, bus.e_wait}, 64'd0);
      end
      bus.stall = 1'b0;
      @(posedge clk); #1;
      bus.valid = 1'b0;
      check("stall release idle", {63'd0, bus.busy}, 64'd0);

      // Flush at T+10
      @(negedge clk);
      bus.valid = 1; bus.op = 3'd4; bus.word = 0; bus.a = 64'd5000; bus.b = 64'd3;
      repeat (10) @(negedge clk);
      bus.flush = 1'b1;
      #1;
      check("flush e_wait", {63'd0, bus.e_wait}, 64'd0);
      @(posedge clk); #1;
      bus.flush = 1'b0; bus.valid = 1'b0;
      check("flush idle", {63'd0, bus.busy}, 64'd0);

      // Reset mid-BUSY, then a fresh DIVU 9/3
      @(negedge clk);
      bus.valid = 1; bus.op = 3'd4; bus.word = 0; bus.a = 64'd77; bus.b = 64'd5;
      repeat (5) @(negedge clk);
      bus.valid = 1'b0;
      reset = 1'b1;
      #1;
      check("rst busy", {63'd0, bus.busy}, 64'd0);
      check("rst e_wait", {63'd0, bus.e_wait}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      issue(3'd5, 1'b0, 64'd9, 64'd3, res, waits);
      check("post-reset DIVU result", res, 64'd3);
      check("post-reset DIVU waits", 64'(waits), 64'd65);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
